ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/cpu_types_pkg.sv | 33 +++
 rtl/ram_arbiter_if.sv | 46 ++++
 rtl/rr_pick.sv | 45 ++++
 rtl/ram_arbiter.sv | 146 ++++++++++++++
 tb/tb_ram_arbiter.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU/memory types: RAM word, RAM handshake state, and the arbiter's
// FSM state and grant-source encodings. Also a helper that sizes an index
// field for N clients (at least one bit, so a single client still has a
// legal grant index).
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    typedef enum logic {
        DATA  = 1'b0,
        INSTR = 1'b1
    } arb_src_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// -----------------------------------------------------------------------------
// ram_arbiter_if
// Bundles every cache-side and RAM-side signal of the RAM arbiter.
//   Cache side (per CPU): iREN, dREN, dWEN, iaddr, daddr, dstore requests;
//                         iwait, dwait stalls and iload, dload read data back.
//   RAM side:             ramREN, ramWEN, ramaddr, ramstore towards the RAM;
//                         ramload, ramstate from the RAM.
// Modports:
//   master - the system around the arbiter (caches + RAM model): drives the
//            requests and the RAM responses.
//   slave  - the arbiter itself.
// -----------------------------------------------------------------------------
interface ram_arbiter_if #(
    parameter int CPUS = 2
);
    import cpu_types_pkg::*;

    logic  [CPUS-1:0] iREN;
    logic  [CPUS-1:0] dREN;
    logic  [CPUS-1:0] dWEN;
    word_t [CPUS-1:0] iaddr;
    word_t [CPUS-1:0] daddr;
    word_t [CPUS-1:0] dstore;
    logic  [CPUS-1:0] iwait;
    logic  [CPUS-1:0] dwait;
    word_t [CPUS-1:0] iload;
    word_t [CPUS-1:0] dload;

    logic             ramREN;
    logic             ramWEN;
    word_t            ramaddr;
    word_t            ramstore;
    word_t            ramload;
    ramstate_t        ramstate;

    modport master (
        output iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport slave (
        input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational rotating-priority picker. Searches req_i starting at
// ptr_i and moving upward, wrapping from N-1 to 0; the first set bit wins.
// Ports:
//   req_i    in  N     request vector
//   ptr_i    in  IW    index searched first
//   onehot_o out N     one-hot of the winner (all zero if none)
//   idx_o    out IW    index of the winner (0 if none)
//   valid_o  out 1     any request present
// -----------------------------------------------------------------------------
module rr_pick
    import cpu_types_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]         req_i,
    input  logic [idx_w(N)-1:0]  ptr_i,
    output logic [N-1:0]         onehot_o,
    output logic [idx_w(N)-1:0]  idx_o,
    output logic                 valid_o
);
    localparam int IW = idx_w(N);

    int c;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        c        = 0;
        for (int i = 0; i < N; i++) begin
            c = int'(ptr_i) + i;
            if (c >= N) begin
                c = c - N;
            end
            if (!valid_o && req_i[c]) begin
                valid_o     = 1'b1;
                onehot_o[c] = 1'b1;
                idx_o       = IW'(c);
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
// Shares one RAM port between CPUS cache pairs (icache + dcache per CPU).
// An IDLE cycle picks one source and registers it; GRANT then steers that
// source alone onto the RAM bus until the RAM reports ACCESS (one-cycle ack
// via the matching wait) or the source withdraws its request.
// Ports:
//   CLK   in  clock, rising edge
//   nRST  in  synchronous active-low reset
//   bus   slave modport of ram_arbiter_if (cache requests/stalls/load data,
//         RAM enables/address/store data, RAM load data/state)
// Parameters:
//   CPUS  number of cache-pair clients (1..8)
//   RR_EN 1 = round-robin across CPUs, 0 = fixed priority (CPU 0 highest)
// -----------------------------------------------------------------------------
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS  = 2,
    parameter bit RR_EN = 1'b1
) (
    input  logic          CLK,
    input  logic          nRST,
    ram_arbiter_if.slave  bus
);
    localparam int GW = idx_w(CPUS);

    arb_state_t      state_q, state_d;
    arb_src_t        gsrc_q, gsrc_d;
    logic [GW-1:0]   gcpu_q, gcpu_d;
    logic [GW-1:0]   rr_q, rr_d;

    logic [CPUS-1:0] data_req;
    logic [CPUS-1:0] any_req;
    logic [CPUS-1:0] pick_onehot;
    logic [GW-1:0]   pick_idx;
    logic [GW-1:0]   pick_ptr;
    logic            pick_valid;

    logic            g_iren, g_dren, g_dwen, g_active;
    word_t           g_iaddr, g_daddr, g_dstore;

    logic            ram_ren, ram_wen;
    word_t           ram_addr, ram_store;
    logic [CPUS-1:0] iwait_c, dwait_c;

    assign data_req = bus.dREN | bus.dWEN;
    assign any_req  = data_req | bus.iREN;

    // Fixed priority is just round-robin with the search always starting at 0.
    assign pick_ptr = RR_EN ? rr_q : '0;

    rr_pick #(.N(CPUS)) u_pick (
        .req_i    (any_req),
        .ptr_i    (pick_ptr),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    // Live view of the granted CPU's request lines.
    assign g_iren   = bus.iREN[gcpu_q];
    assign g_dren   = bus.dREN[gcpu_q];
    assign g_dwen   = bus.dWEN[gcpu_q];
    assign g_iaddr  = bus.iaddr[gcpu_q];
    assign g_daddr  = bus.daddr[gcpu_q];
    assign g_dstore = bus.dstore[gcpu_q];
    assign g_active = (gsrc_q == DATA) ? (g_dren | g_dwen) : g_iren;

    always_comb begin
        state_d   = state_q;
        gsrc_d    = gsrc_q;
        gcpu_d    = gcpu_q;
        rr_d      = rr_q;
        ram_ren   = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_store = '0;
        iwait_c   = '1;
        dwait_c   = '1;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = GRANT;
                    gcpu_d  = pick_idx;
                    // Data side of the winning CPU beats its instruction side.
                    gsrc_d  = (|(pick_onehot & data_req)) ? DATA : INSTR;
                end
            end
            GRANT: begin
                if (gsrc_q == DATA) begin
                    // A simultaneous read and write resolves to the write.
                    ram_wen   = g_dwen;
                    ram_ren   = g_dren & ~g_dwen;
                    ram_addr  = g_daddr;
                    ram_store = g_dstore;
                end else begin
                    ram_ren   = g_iren;
                    ram_addr  = g_iaddr;
                end
                if (!g_active) begin
                    // Requester withdrew: abandon without ack or pointer move.
                    state_d = IDLE;
                end else if (bus.ramstate == ACCESS) begin
                    state_d = IDLE;
                    if (gsrc_q == DATA) begin
                        dwait_c[gcpu_q] = 1'b0;
                    end else begin
                        iwait_c[gcpu_q] = 1'b0;
                    end
                    if (RR_EN) begin
                        rr_d = (gcpu_q == GW'(CPUS - 1)) ? '0 : gcpu_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            gsrc_q  <= DATA;
            gcpu_q  <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            gsrc_q  <= gsrc_d;
            gcpu_q  <= gcpu_d;
            rr_q    <= rr_d;
        end
    end

    assign bus.ramREN   = ram_ren;
    assign bus.ramWEN   = ram_wen;
    assign bus.ramaddr  = ram_addr;
    assign bus.ramstore = ram_store;
    assign bus.iwait    = iwait_c;
    assign bus.dwait    = dwait_c;
    // Load data is broadcast; the wait lines say who may use it.
    assign bus.iload    = {CPUS{bus.ramload}};
    assign bus.dload    = {CPUS{bus.ramload}};

endmodule

// File: tb/tb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_arbiter
// Directed bench for ram_arbiter: two CPUS=2 instances (round-robin and fixed
// priority) and one CPUS=4 round-robin instance sharing clock and reset.
// -----------------------------------------------------------------------------
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    logic CLK;
    logic nRST;

    int vectors;
    int miscompares;

    ram_arbiter_if #(.CPUS(2)) ifa ();
    ram_arbiter_if #(.CPUS(2)) ifb ();
    ram_arbiter_if #(.CPUS(4)) ifc ();

    ram_arbiter #(.CPUS(2), .RR_EN(1'b1)) dut_a (.CLK(CLK), .nRST(nRST), .bus(ifa));
    ram_arbiter #(.CPUS(2), .RR_EN(1'b0)) dut_b (.CLK(CLK), .nRST(nRST), .bus(ifb));
    ram_arbiter #(.CPUS(4), .RR_EN(1'b1)) dut_c (.CLK(CLK), .nRST(nRST), .bus(ifc));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        nRST        = 1'b0;

        ifa.iREN = '0; ifa.dREN = '0; ifa.dWEN = '0;
        ifa.iaddr = '0; ifa.daddr = '0; ifa.dstore = '0;
        ifa.ramload = '0; ifa.ramstate = FREE;
        ifb.iREN = '0; ifb.dREN = '0; ifb.dWEN = '0;
        ifb.iaddr = '0; ifb.daddr = '0; ifb.dstore = '0;
        ifb.ramload = '0; ifb.ramstate = FREE;
        ifc.iREN = '0; ifc.dREN = '0; ifc.dWEN = '0;
        ifc.iaddr = '0; ifc.daddr = '0; ifc.dstore = '0;
        ifc.ramload = '0; ifc.ramstate = FREE;

        // ---- reset state
        tick();
        tick();
        chk("rst_iwait", ifa.iwait, 32'h3);
        chk("rst_dwait", ifa.dwait, 32'h3);
        chk("rst_ramREN", ifa.ramREN, 32'h0);
        chk("rst_ramWEN", ifa.ramWEN, 32'h0);
        chk("rst_ramaddr", ifa.ramaddr, 32'h0);
        chk("rst_ramstore", ifa.ramstore, 32'h0);
        chk("rst_c_dwait", ifc.dwait, 32'hF);
        nRST = 1'b1;

        // ---- single icache read, CPU0
        ifa.iREN = 2'b01;
        ifa.iaddr[0] = 32'h40;
        #1;
        chk("single_idle_ramREN", ifa.ramREN, 32'h0);
        tick();
        ifa.ramstate = BUSY;
        #1;
        chk("single_grant_ramREN", ifa.ramREN, 32'h1);
        chk("single_grant_ramaddr", ifa.ramaddr, 32'h40);
        chk("single_busy_iwait", ifa.iwait, 32'h3);
        tick();
        ifa.ramstate = ACCESS;
        ifa.ramload = 32'hDEADBEEF;
        #1;
        chk("single_ack_iwait", ifa.iwait, 32'h2);
        chk("single_ack_dwait", ifa.dwait, 32'h3);
        chk("single_iload", ifa.iload[0], 32'hDEADBEEF);
        chk("single_dload1", ifa.dload[1], 32'hDEADBEEF);
        tick();
        ifa.iREN = 2'b00;
        ifa.ramstate = FREE;
        #1;
        chk("single_after_iwait", ifa.iwait, 32'h3);
        chk("single_after_ramREN", ifa.ramREN, 32'h0);

        // ---- CPU1 write beats its own instruction read
        ifa.dWEN = 2'b10;
        ifa.iREN = 2'b10;
        ifa.daddr[1] = 32'h80;
        ifa.dstore[1] = 32'h1234;
        ifa.iaddr[1] = 32'h100;
        #1;
        tick();
        chk("prio_wr_ramWEN", ifa.ramWEN, 32'h1);
        chk("prio_wr_ramREN", ifa.ramREN, 32'h0);
        chk("prio_wr_ramaddr", ifa.ramaddr, 32'h80);
        chk("prio_wr_ramstore", ifa.ramstore, 32'h1234);
        tick();
        ifa.ramstate = ACCESS;
        #1;
        chk("prio_wr_dwait", ifa.dwait, 32'h1);
        chk("prio_wr_iwait", ifa.iwait, 32'h3);
        tick();
        ifa.dWEN = 2'b00;
        ifa.ramstate = FREE;
        #1;
        chk("prio_idle_ramaddr", ifa.ramaddr, 32'h0);
        chk("prio_idle_ramstore", ifa.ramstore, 32'h0);
        tick();
        ifa.ramstate = ACCESS;
        #1;
        chk("prio_rd_ramREN", ifa.ramREN, 32'h1);
        chk("prio_rd_ramaddr", ifa.ramaddr, 32'h100);
        chk("prio_rd_ramstore", ifa.ramstore, 32'h0);
        chk("prio_rd_iwait", ifa.iwait, 32'h1);
        tick();
        ifa.iREN = 2'b00;
        ifa.ramstate = FREE;
        #1;

        // ---- round-robin with all four sources requesting
        ifa.iREN = 2'b11;
        ifa.dREN = 2'b11;
        ifa.daddr[0] = 32'h200;
        ifa.daddr[1] = 32'h300;
        ifa.ramstate = ACCESS;
        #1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rr_addr_%0d", k), ifa.ramaddr, (k % 2 == 0) ? 32'h200 : 32'h300);
            chk($sformatf("rr_dwait_%0d", k), ifa.dwait, (k % 2 == 0) ? 32'h2 : 32'h1);
            chk($sformatf("rr_iwait_%0d", k), ifa.iwait, 32'h3);
            tick();
            chk($sformatf("rr_idle_dwait_%0d", k), ifa.dwait, 32'h3);
        end
        ifa.iREN = 2'b00;
        ifa.dREN = 2'b00;
        ifa.ramstate = FREE;

        // ---- fixed priority: CPU0 only until it drops
        ifb.dREN = 2'b11;
        ifb.daddr[0] = 32'hA0;
        ifb.daddr[1] = 32'hB0;
        ifb.ramstate = ACCESS;
        #1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("fixed_addr_%0d", k), ifb.ramaddr, 32'hA0);
            chk($sformatf("fixed_dwait_%0d", k), ifb.dwait, 32'h2);
            tick();
        end
        ifb.dREN = 2'b10;
        tick();
        chk("fixed_cpu1_addr", ifb.ramaddr, 32'hB0);
        chk("fixed_cpu1_dwait", ifb.dwait, 32'h1);
        tick();
        ifb.dREN = 2'b00;
        ifb.ramstate = FREE;
        #1;

        // ---- ERROR holds without ack, then abort under BUSY
        ifa.dREN = 2'b01;
        ifa.daddr[0] = 32'h500;
        ifa.ramstate = ERROR;
        #1;
        tick();
        chk("abort_grant_ramREN", ifa.ramREN, 32'h1);
        chk("abort_grant_ramaddr", ifa.ramaddr, 32'h500);
        chk("abort_error_dwait", ifa.dwait, 32'h3);
        tick();
        ifa.ramstate = BUSY;
        ifa.dREN = 2'b00;
        #1;
        chk("abort_drop_dwait", ifa.dwait, 32'h3);
        chk("abort_drop_ramREN", ifa.ramREN, 32'h0);
        tick();
        chk("abort_idle_ramaddr", ifa.ramaddr, 32'h0);
        chk("abort_idle_dwait", ifa.dwait, 32'h3);
        // pointer must still be 0: CPU0 wins over CPU1
        ifa.dREN = 2'b11;
        ifa.daddr[1] = 32'h600;
        ifa.ramstate = ACCESS;
        tick();
        chk("abort_ptr_ramaddr", ifa.ramaddr, 32'h500);
        chk("abort_ptr_dwait", ifa.dwait, 32'h2);
        tick();

        // ---- reset while CPU1 holds a BUSY grant (pointer is 1 here)
        ifa.dREN = 2'b10;
        ifa.ramstate = BUSY;
        #1;
        tick();
        chk("rstmid_grant_ramaddr", ifa.ramaddr, 32'h600);
        chk("rstmid_grant_ramREN", ifa.ramREN, 32'h1);
        nRST = 1'b0;
        tick();
        chk("rstmid_iwait", ifa.iwait, 32'h3);
        chk("rstmid_dwait", ifa.dwait, 32'h3);
        chk("rstmid_ramREN", ifa.ramREN, 32'h0);
        chk("rstmid_ramWEN", ifa.ramWEN, 32'h0);
        chk("rstmid_ramaddr", ifa.ramaddr, 32'h0);
        nRST = 1'b1;
        ifa.dREN = 2'b11;
        ifa.ramstate = ACCESS;
        tick();
        chk("rstmid_first_ramaddr", ifa.ramaddr, 32'h500);
        chk("rstmid_first_dwait", ifa.dwait, 32'h2);
        tick();
        ifa.dREN = 2'b00;
        ifa.ramstate = FREE;
        #1;

        // ---- CPUS=4 pointer wrap from 3 to 0
        ifc.dREN = 4'b0100;
        ifc.daddr[0] = 32'h1000;
        ifc.daddr[2] = 32'h2000;
        ifc.daddr[3] = 32'h3000;
        ifc.ramstate = ACCESS;
        #1;
        tick();
        chk("wrap_cpu2_addr", ifc.ramaddr, 32'h2000);
        chk("wrap_cpu2_dwait", ifc.dwait, 32'hB);
        tick();
        ifc.dREN = 4'b1001;
        #1;
        tick();
        chk("wrap_cpu3_addr", ifc.ramaddr, 32'h3000);
        chk("wrap_cpu3_dwait", ifc.dwait, 32'h7);
        tick();
        chk("wrap_idle_dwait", ifc.dwait, 32'hF);
        tick();
        chk("wrap_cpu0_addr", ifc.ramaddr, 32'h1000);
        chk("wrap_cpu0_dwait", ifc.dwait, 32'hE);
        tick();
        ifc.dREN = 4'b0000;
        ifc.ramstate = FREE;
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
